dm_cache_ctrl: RTL and testbench



---
 rtl/dm_cache_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_def (package) / dm_cache_ctrl
//  Description : Direct-mapped, write-back, write-allocate cache controller.
//                1024 lines x 128 bits, 18-bit tag, valid + dirty per line.
//                Four-state FSM between the CPU load/store port and a
//                block-wide memory interface.
//  Revision    : 1.0 - initial release
// ============================================================================

package cache_def;
   localparam int TAGMSB = 31;
   localparam int TAGLSB = 14;

   typedef logic [TAGMSB-TAGLSB:0] cache_tag_type;   // 18-bit tag
   typedef logic [9:0]             cache_idx_type;   // 1024 lines
   typedef logic [127:0]           cache_data_type;  // one line

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;     // 0 = read, 1 = write
      logic        valid;
   } cpu_req_type;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } cpu_result_type;

   typedef struct packed {
      logic [31:0]    addr;
      cache_data_type data;
      logic           rw;
      logic           valid;
   } mem_req_type;

   typedef struct packed {
      cache_data_type data;
      logic           ready;
   } mem_data_type;
endpackage

module dm_cache_ctrl
   import cache_def::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  cpu_req_type    cpu_req,
   output cpu_result_type cpu_res,
   output mem_req_type    mem_req,
   input  mem_data_type   mem_data
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      COMPARE    = 2'd1,
      WRITE_BACK = 2'd2,
      ALLOCATE   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   cache_tag_type  req_tag_q, req_tag_d;
   cache_idx_type  req_idx_q, req_idx_d;
   logic [1:0]     req_word_q, req_word_d;
   logic [31:0]    req_data_q, req_data_d;
   logic           req_rw_q, req_rw_d;
   logic [1023:0]  valid_q, valid_d;
   logic [1023:0]  dirty_q, dirty_d;

   // Tag and data storage; deliberately not reset
   cache_tag_type  tag_arr  [0:1023];
   cache_data_type data_arr [0:1023];

   cache_tag_type  w_tag_rd;
   cache_data_type w_line_rd;
   logic           w_hit;
   logic [31:0]    w_word_rd;
   logic           w_line_we;
   cache_data_type w_line_wdata;
   logic           w_tag_we;

   // Byte-offset bits and the request valid bit are not stored
   logic           w_unused;
   assign w_unused = ^{cpu_req.addr[1:0]};

   assign w_tag_rd  = tag_arr[req_idx_q];
   assign w_line_rd = data_arr[req_idx_q];
   assign w_hit     = valid_q[req_idx_q] && (w_tag_rd == req_tag_q);
   assign w_word_rd = w_line_rd[{req_word_q, 5'b0} +: 32];

   // Next-state, request capture, array update enables and outputs
   always_comb begin
      state_d      = state_q;
      req_tag_d    = req_tag_q;
      req_idx_d    = req_idx_q;
      req_word_d   = req_word_q;
      req_data_d   = req_data_q;
      req_rw_d     = req_rw_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      w_line_we    = 1'b0;
      w_line_wdata = w_line_rd;
      w_tag_we     = 1'b0;
      cpu_res      = '0;
      mem_req      = '0;

      case (state_q)
         IDLE: begin
            if (cpu_req.valid) begin
               req_tag_d  = cpu_req.addr[TAGMSB:TAGLSB];
               req_idx_d  = cpu_req.addr[13:4];
               req_word_d = cpu_req.addr[3:2];
               req_data_d = cpu_req.data;
               req_rw_d   = cpu_req.rw;
               state_d    = COMPARE;
            end
         end
         COMPARE: begin
            if (w_hit) begin
               cpu_res.ready = 1'b1;
               cpu_res.data  = w_word_rd;
               if (req_rw_q) begin
                  w_line_we = 1'b1;
                  w_line_wdata[{req_word_q, 5'b0} +: 32] = req_data_q;
                  dirty_d[req_idx_q] = 1'b1;
               end
               state_d = IDLE;
            end else if (valid_q[req_idx_q] && dirty_q[req_idx_q]) begin
               state_d = WRITE_BACK;
            end else begin
               state_d = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            // Victim address comes from the stored tag, not the request tag
            mem_req.addr  = {w_tag_rd, req_idx_q, 4'b0};
            mem_req.data  = w_line_rd;
            mem_req.rw    = 1'b1;
            mem_req.valid = 1'b1;
            if (mem_data.ready) begin
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            mem_req.addr  = {req_tag_q, req_idx_q, 4'b0};
            mem_req.rw    = 1'b0;
            mem_req.valid = 1'b1;
            if (mem_data.ready) begin
               w_line_we          = 1'b1;
               w_line_wdata       = mem_data.data;
               w_tag_we           = 1'b1;
               valid_d[req_idx_q] = 1'b1;
               dirty_d[req_idx_q] = 1'b0;
               state_d            = COMPARE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, request register and line status bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_tag_q  <= '0;
         req_idx_q  <= '0;
         req_word_q <= '0;
         req_data_q <= '0;
         req_rw_q   <= 1'b0;
         valid_q    <= '0;
         dirty_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_tag_q  <= req_tag_d;
         req_idx_q  <= req_idx_d;
         req_word_q <= req_word_d;
         req_data_q <= req_data_d;
         req_rw_q   <= req_rw_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
      end
   end

   // Tag/data array writes; gated by state, which reset forces to IDLE
   always_ff @(posedge clk) begin
      if (w_line_we) begin
         data_arr[req_idx_q] <= w_line_wdata;
      end
      if (w_tag_we) begin
         tag_arr[req_idx_q] <= req_tag_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_cache_ctrl
//  Description : Self-checking bench for dm_cache_ctrl. A transaction-level
//                cache + memory model predicts the per-cycle outputs; a
//                negedge compare process checks them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;
   import cache_def::*;

   logic           clk = 1'b0;
   logic           rst_n;
   cpu_req_type    cpu_req;
   cpu_result_type cpu_res;
   mem_req_type    mem_req;
   mem_data_type   mem_data;

   always #5 clk = ~clk;

   dm_cache_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu_req  (cpu_req),
      .cpu_res  (cpu_res),
      .mem_req  (mem_req),
      .mem_data (mem_data)
   );

   // Behavioural model: cache contents and backing memory
   bit         m_valid [1024];
   bit         m_dirty [1024];
   bit [17:0]  m_tag   [1024];
   bit [127:0] m_line  [1024];
   bit [127:0] mem_model [bit [31:0]];

   // Expected outputs for the current cycle
   bit          chk_en;
   bit          e_ready, e_rd_check, e_mvalid, e_mrw, e_mdata_care;
   logic [31:0] e_rdata, e_maddr;
   logic [127:0] e_mdata;

   int n_cmp  = 0;
   int n_fail = 0;

   // Values captured from the DUT for hand-computed literal checks
   logic [31:0]  cap_rdata, cap_wb_addr, cap_al_addr;
   logic [127:0] cap_wb_data;

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Per-cycle comparison against the model's expectations
   always @(negedge clk) begin
      if (chk_en) begin
         check("cpu_ready", 128'(cpu_res.ready), 128'(e_ready));
         if (e_ready) begin
            if (e_rd_check) check("cpu_rdata", 128'(cpu_res.data), 128'(e_rdata));
         end else begin
            check("cpu_data_idle", 128'(cpu_res.data), 128'(0));
         end
         check("mem_valid", 128'(mem_req.valid), 128'(e_mvalid));
         check("mem_addr", 128'(mem_req.addr), e_mvalid ? 128'(e_maddr) : 128'(0));
         check("mem_rw", 128'(mem_req.rw), e_mvalid ? 128'(e_mrw) : 128'(0));
         if (!e_mvalid) check("mem_data_idle", mem_req.data, 128'(0));
         else if (e_mdata_care) check("mem_wb_data", mem_req.data, e_mdata);
         if (cpu_res.ready && e_rd_check) cap_rdata = cpu_res.data;
         if (mem_req.valid && mem_req.rw) begin
            cap_wb_addr = mem_req.addr;
            cap_wb_data = mem_req.data;
         end
         if (mem_req.valid && !mem_req.rw) cap_al_addr = mem_req.addr;
      end
   end

   task automatic set_idle_exp();
      e_ready = 0; e_rd_check = 0; e_rdata = '0;
      e_mvalid = 0; e_maddr = '0; e_mrw = 0; e_mdata_care = 0; e_mdata = '0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic bit [127:0] mem_read(bit [31:0] a);
      if (!mem_model.exists(a)) mem_model[a] = rnd128();
      return mem_model[a];
   endfunction

   // One CPU access; entered and left in an IDLE cycle. abort_at >= 0 asserts
   // reset in that ALLOCATE cycle and abandons the access.
   task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input bit rw,
                         input int wb_lat, input int al_lat, input bit zw, input int abort_at);
      bit [17:0]  tag  = addr[31:14];
      bit [9:0]   idx  = addr[13:4];
      bit [1:0]   word = addr[3:2];
      bit [31:0]  va, la;
      bit [127:0] line;

      set_idle_exp();
      cpu_req.addr = addr; cpu_req.data = wdata; cpu_req.rw = rw; cpu_req.valid = 1'b1;
      mem_data.ready = zw ? 1'b1 : 1'($urandom_range(0, 1));
      mem_data.data  = rnd128();
      next_cyc();
      cpu_req.addr = $urandom; cpu_req.data = $urandom;
      cpu_req.rw = 1'($urandom); cpu_req.valid = 1'($urandom);

      if (!(m_valid[idx] && m_tag[idx] == tag)) begin
         set_idle_exp();
         mem_data.ready = zw ? 1'b1 : 1'($urandom_range(0, 1));
         next_cyc();
         if (m_valid[idx] && m_dirty[idx]) begin
            va = {m_tag[idx], idx, 4'b0};
            for (int c = 0; c <= wb_lat; c++) begin
               set_idle_exp();
               e_mvalid = 1; e_maddr = va; e_mrw = 1; e_mdata_care = 1; e_mdata = m_line[idx];
               mem_data.ready = (c == wb_lat);
               mem_data.data  = rnd128();
               next_cyc();
            end
            mem_model[va] = m_line[idx];
         end
         la   = {tag, idx, 4'b0};
         line = mem_read(la);
         for (int c = 0; c <= al_lat; c++) begin
            set_idle_exp();
            e_mvalid = 1; e_maddr = la; e_mrw = 0;
            mem_data.ready = (c == al_lat);
            mem_data.data  = (c == al_lat) ? line : rnd128();
            if (c == abort_at) begin
               rst_n = 1'b0;
               #1;
               check("abort_mem_valid", 128'(mem_req.valid), 128'(0));
               check("abort_mem_req", 128'(mem_req), 128'(0));
               check("abort_cpu_res", 128'(cpu_res), 128'(0));
               for (int i = 0; i < 1024; i++) begin
                  m_valid[i] = 0;
                  m_dirty[i] = 0;
               end
               set_idle_exp();
               cpu_req.valid  = 1'b0;
               mem_data.ready = 1'b1;
               mem_data.data  = line;
               next_cyc();
               next_cyc();
               #2 rst_n = 1'b1;
               for (int i = 0; i < 3; i++) next_cyc();
               mem_data.ready = 1'b0;
               return;
            end
            next_cyc();
         end
         m_line[idx] = line; m_tag[idx] = tag; m_valid[idx] = 1; m_dirty[idx] = 0;
      end

      set_idle_exp();
      e_ready = 1; e_rd_check = !rw; e_rdata = m_line[idx][32*word +: 32];
      mem_data.ready = zw ? 1'b1 : 1'($urandom_range(0, 1));
      if (rw) begin
         m_line[idx][32*word +: 32] = wdata;
         m_dirty[idx] = 1;
      end
      next_cyc();
      set_idle_exp();
      cpu_req.valid  = 1'b0;
      mem_data.ready = zw ? 1'b1 : 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit [9:0] idx_pool [4];
      idx_pool[0] = 10'h100; idx_pool[1] = 10'h3FF; idx_pool[2] = 10'h000; idx_pool[3] = 10'h005;

      rst_n = 1'b0;
      cpu_req = '0;
      mem_data = '0;
      set_idle_exp();
      chk_en = 1'b1;
      #1;
      check("reset_cpu_res", 128'(cpu_res), 128'(0));
      check("reset_mem_req", 128'(mem_req), 128'(0));
      repeat (3) next_cyc();
      rst_n = 1'b1;
      next_cyc();

      // Clean read miss with 3-cycle memory
      mem_model[32'h0000_1000] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      access(32'h0000_1004, 32'h0, 1'b0, 0, 2, 1'b0, -1);
      check("lit_rd_1004", 128'(cap_rdata), 128'h2222_2222);
      check("lit_al_1000", 128'(cap_al_addr), 128'h0000_1000);

      // Write hit then read-back
      access(32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 0, 0, 1'b0, -1);
      access(32'h0000_1004, 32'h0, 1'b0, 0, 0, 1'b0, -1);
      check("lit_rd_deadbeef", 128'(cap_rdata), 128'hDEAD_BEEF);

      // Conflict miss on a dirty line
      access(32'h0000_5004, 32'h0, 1'b0, 1, 1, 1'b0, -1);
      check("lit_wb_addr_1000", 128'(cap_wb_addr), 128'h0000_1000);
      check("lit_wb_word1", 128'(cap_wb_data[63:32]), 128'hDEAD_BEEF);
      check("lit_wb_word0", 128'(cap_wb_data[31:0]), 128'h1111_1111);
      check("lit_al_5000", 128'(cap_al_addr), 128'h0000_5000);

      // Write miss on clean index 0x3FF, then conflicting read
      access(32'h0000_3FF8, 32'h0BAD_F00D, 1'b1, 0, 1, 1'b0, -1);
      access(32'h0000_7FF8, 32'h0, 1'b0, 2, 0, 1'b0, -1);
      check("lit_wb_addr_3ff0", 128'(cap_wb_addr), 128'h0000_3FF0);
      check("lit_wb_word2", 128'(cap_wb_data[95:64]), 128'h0BAD_F00D);

      // Zero-wait memory, ready held high throughout
      access(32'h0000_9004, 32'h1234_5678, 1'b1, 0, 0, 1'b1, -1);
      access(32'h0000_D00C, 32'h0, 1'b0, 0, 0, 1'b1, -1);
      access(32'h0000_9004, 32'h0, 1'b0, 0, 0, 1'b1, -1);
      check("lit_zw_rd", 128'(cap_rdata), 128'h1234_5678);
      mem_data.ready = 1'b0;

      // Randomized traffic over a few conflicting indices
      for (int n = 0; n < 300; n++) begin
         bit [31:0] a;
         bit        zw = ($urandom_range(0, 3) == 0);
         a = {14'($urandom_range(0, 3)), idx_pool[$urandom_range(0, 3)],
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         access(a, $urandom, 1'($urandom), zw ? 0 : int'($urandom_range(0, 3)),
                zw ? 0 : int'($urandom_range(0, 3)), zw, -1);
         mem_data.ready = 1'b0;
      end

      // Reset in the middle of ALLOCATE, then the old line must miss
      access(32'h0000_1004, 32'h0, 1'b0, 1, 1, 1'b0, -1);
      access(32'h0000_D004, 32'h0, 1'b0, 1, 3, 1'b0, 1);
      check("lit_abort_al_addr", 128'(cap_al_addr), 128'h0000_D000);
      access(32'h0000_1004, 32'h0, 1'b0, 0, 1, 1'b0, -1);
      check("lit_post_reset_miss", 128'(cap_al_addr), 128'h0000_1000);

      next_cyc();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
